// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
package CustomTypes;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_t;

  // Widest strobe vector supported; sliced to DATA_WIDTH/8 where used.
  localparam int unsigned MaxStrobeW = 64;

  // Idle value of the memory byte strobes.
  localparam logic [MaxStrobeW-1:0] EMPTY = '0;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requestor and memory bus of the memory arbiter.
// slave: arbiter side. master: requestors plus memory side.
interface memory_arbiter_if #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned IdW = $clog2(CHANNELS);

  logic                               delete_tagged;
  logic [CHANNELS-1:0]                ch_req;
  logic [CHANNELS-1:0]                ch_write;
  logic [CHANNELS*ADDR_WIDTH-1:0]     ch_address;
  logic [CHANNELS*DATA_WIDTH-1:0]     ch_wdata;
  logic [CHANNELS*DATA_WIDTH/8-1:0]   ch_ws;
  logic [CHANNELS-1:0]                ch_ready;
  logic [DATA_WIDTH-1:0]              ch_rdata;
  logic                               ch_error;
  logic                               mem_read;
  logic                               mem_write;
  logic [ADDR_WIDTH-1:0]              mem_address;
  logic [DATA_WIDTH-1:0]              mem_wdata;
  logic [DATA_WIDTH/8-1:0]            mem_ws;
  logic [IdW-1:0]                     mem_source;
  logic [DATA_WIDTH-1:0]              mem_rdata;
  logic                               mem_ready;
  logic                               mem_done;

  modport slave (
    input  delete_tagged, ch_req, ch_write, ch_address, ch_wdata, ch_ws,
    input  mem_rdata, mem_ready, mem_done,
    output ch_ready, ch_rdata, ch_error,
    output mem_read, mem_write, mem_address, mem_wdata, mem_ws, mem_source
  );

  modport master (
    output delete_tagged, ch_req, ch_write, ch_address, ch_wdata, ch_ws,
    output mem_rdata, mem_ready, mem_done,
    input  ch_ready, ch_rdata, ch_error,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_ws, mem_source
  );

endinterface

// File: rtl/memory_arbiter_rr_arbiter.sv
// Round-robin grant selection: first requesting channel at or after ptr_i.
module rr_arbiter #(
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned IdW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IdW-1:0]      ptr_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [IdW-1:0]      id_o
);

  int unsigned idx;
  logic        found;

  // Scan channels in rotating order from the pointer, take the first request.
  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = (32'(ptr_i) + i) % CHANNELS;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Multi-channel memory arbiter, one outstanding transaction at a time.
// Optional watchdog: define MEMORY_ARBITER_TIMEOUT_EN to bound the WAIT state.
module memory_arbiter
  import CustomTypes::*;
#(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             reset,
  memory_arbiter_if.slave bus
);

  localparam int unsigned IdW   = $clog2(CHANNELS);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  if (CHANNELS < 2 || CHANNELS > 8 || (DATA_WIDTH % 8) != 0 || StrbW > MaxStrobeW ||
      TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("memory_arbiter: illegal parameter set");
  end

  arb_state_t            state_q, state_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [CHANNELS-1:0]   oh_q, oh_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]      ws_q, ws_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [CHANNELS-1:0]   elig;
  logic [CHANNELS-1:0]   arb_gnt;
  logic [IdW-1:0]        arb_id;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
`endif

  // Flush makes channel 0 ineligible for the current cycle.
  assign elig = bus.ch_req & ~{{(CHANNELS-1){1'b0}}, bus.delete_tagged};

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_rr_arbiter (
    .req_i  (elig),
    .ptr_i  (ptr_q),
    .grant_o(arb_gnt),
    .id_o   (arb_id)
  );

  // State and transaction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      oh_q    <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ws_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      oh_q    <= oh_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ws_q    <= ws_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  // Watchdog counter and timeout-completion flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  // Counter runs only while waiting on memory.
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT && state_d == WAIT) tmo_d = tmo_q + TmoW'(1);
  end
`endif

  // Next-state: grant in IDLE, wait for memory, one-cycle response.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    oh_d    = oh_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ws_d    = ws_q;
    rdata_d = rdata_q;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = WAIT;
          id_d    = arb_id;
          oh_d    = arb_gnt;
          write_d = bus.ch_write[arb_id];
          addr_d  = bus.ch_address[32'(arb_id)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus.ch_wdata[32'(arb_id)*DATA_WIDTH +: DATA_WIDTH];
          ws_d    = bus.ch_ws[32'(arb_id)*StrbW +: StrbW];
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      WAIT: begin
        // Strobe of the wrong kind for the current command is ignored.
        if (bus.delete_tagged && id_q == '0) begin
          state_d = IDLE;
        end else if (write_q ? bus.mem_done : bus.mem_ready) begin
          if (!write_q) rdata_d = bus.mem_rdata;
          state_d = RESP;
        end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        else if (tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        ptr_d   = (id_q == IdW'(CHANNELS - 1)) ? '0 : id_q + IdW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory command only while waiting, completion pulse in RESP.
  always_comb begin
    bus.mem_read    = (state_q == WAIT) && !write_q;
    bus.mem_write   = (state_q == WAIT) && write_q;
    bus.mem_address = (state_q == WAIT) ? addr_q : '0;
    bus.mem_wdata   = (state_q == WAIT) ? wdata_q : '0;
    bus.mem_ws      = (state_q == WAIT) ? ws_q : EMPTY[StrbW-1:0];
    bus.mem_source  = id_q;
    bus.ch_ready    = (state_q == RESP) ? oh_q : '0;
    bus.ch_rdata    = rdata_q;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    bus.ch_error    = (state_q == RESP) && err_q;
`else
    bus.ch_error    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (CHANNELS = 2, 32-bit address/data).
module tb_memory_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  memory_arbiter_if #(
    .CHANNELS  (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) bus ();

  memory_arbiter #(
    .CHANNELS      (2),
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] ws);
    bus.ch_write[ch]            = wr;
    bus.ch_address[ch*32 +: 32] = addr;
    bus.ch_wdata[ch*32 +: 32]   = wdata;
    bus.ch_ws[ch*4 +: 4]        = ws;
  endtask

  // One read with both channels requesting; memory answers one cycle after the command.
  task automatic rd_txn(input int exp_id, input logic [31:0] data);
    step();
    check("rr_src", 64'(bus.mem_source), 64'(exp_id));
    check("rr_read", 64'(bus.mem_read), 64'd1);
    bus.mem_rdata = data;
    bus.mem_ready = 1'b1;
    step();
    check("rr_ready", 64'(bus.ch_ready), 64'(1 << exp_id));
    check("rr_rdata", 64'(bus.ch_rdata), 64'(data));
    bus.mem_ready = 1'b0;
    step();
    check("rr_idle", 64'(bus.ch_ready), 64'd0);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    reset             = 1'b1;
    bus.delete_tagged = 1'b0;
    bus.ch_req        = '0;
    bus.ch_write      = '0;
    bus.ch_address    = '0;
    bus.ch_wdata      = '0;
    bus.ch_ws         = '0;
    bus.mem_rdata     = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_done      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.ch_ready), 64'd0);
    check("rst_rdata", 64'(bus.ch_rdata), 64'd0);
    check("rst_error", 64'(bus.ch_error), 64'd0);
    check("rst_mem_read", 64'(bus.mem_read), 64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_address), 64'd0);
    check("rst_mem_ws", 64'(bus.mem_ws), 64'd0);
    check("rst_mem_src", 64'(bus.mem_source), 64'd0);
    reset = 1'b0;

    // ch0 read of 0x100, data returned two cycles after the request.
    set_ch(0, 1'b0, 32'h100, 32'h0, 4'h0);
    bus.ch_req = 2'b01;
    step();
    check("rd_mem_read", 64'(bus.mem_read), 64'd1);
    check("rd_mem_addr", 64'(bus.mem_address), 64'h100);
    check("rd_mem_src", 64'(bus.mem_source), 64'd0);
    check("rd_no_ready", 64'(bus.ch_ready), 64'd0);
    step();
    check("rd_hold_addr", 64'(bus.mem_address), 64'h100);
    bus.mem_rdata = 32'hDEADBEEF;
    bus.mem_ready = 1'b1;
    step();
    check("rd_ready", 64'(bus.ch_ready), 64'b01);
    check("rd_rdata", 64'(bus.ch_rdata), 64'hDEADBEEF);
    check("rd_cmd_drop", 64'(bus.mem_read), 64'd0);
    check("rd_mem_addr0", 64'(bus.mem_address), 64'd0);
    bus.ch_req    = 2'b00;
    bus.mem_ready = 1'b0;
    step();
    check("rd_pulse_once", 64'(bus.ch_ready), 64'd0);
    check("rd_rdata_hold", 64'(bus.ch_rdata), 64'hDEADBEEF);

    // Reset pulse clears rr_ptr and the read-data register.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_rdata", 64'(bus.ch_rdata), 64'd0);

    // Both channels request three times: grants 0, 1, 0.
    set_ch(1, 1'b0, 32'h180, 32'h0, 4'h0);
    bus.ch_req = 2'b11;
    rd_txn(0, 32'h11111111);
    rd_txn(1, 32'h22222222);
    rd_txn(0, 32'h33333333);
    bus.ch_req = 2'b00;

    // ch1 write with partial strobes; a stray mem_ready must not complete it.
    set_ch(1, 1'b1, 32'h200, 32'hCAFEF00D, 4'b0011);
    bus.ch_req = 2'b10;
    step();
    check("wr_mem_write", 64'(bus.mem_write), 64'd1);
    check("wr_mem_read", 64'(bus.mem_read), 64'd0);
    check("wr_addr", 64'(bus.mem_address), 64'h200);
    check("wr_wdata", 64'(bus.mem_wdata), 64'hCAFEF00D);
    check("wr_ws", 64'(bus.mem_ws), 64'b0011);
    check("wr_src", 64'(bus.mem_source), 64'd1);
    bus.mem_ready = 1'b1;
    step();
    check("wr_ignore_ready", 64'(bus.mem_write), 64'd1);
    check("wr_ignore_rdy2", 64'(bus.ch_ready), 64'd0);
    check("wr_hold_wdata", 64'(bus.mem_wdata), 64'hCAFEF00D);
    bus.mem_ready = 1'b0;
    bus.mem_done  = 1'b1;
    step();
    check("wr_ready", 64'(bus.ch_ready), 64'b10);
    check("wr_cmd_drop", 64'(bus.mem_write), 64'd0);
    check("wr_ws_zero", 64'(bus.mem_ws), 64'd0);
    check("wr_rdata_kept", 64'(bus.ch_rdata), 64'h33333333);
    check("wr_no_error", 64'(bus.ch_error), 64'd0);
    bus.ch_req   = 2'b00;
    bus.mem_done = 1'b0;
    step();
    check("wr_idle", 64'(bus.ch_ready), 64'd0);

    // Flush during a ch0 wait, then ch1 is granted even with ch0 still asking.
    set_ch(0, 1'b0, 32'h100, 32'h0, 4'h0);
    set_ch(1, 1'b0, 32'h300, 32'h0, 4'h0);
    bus.ch_req = 2'b01;
    step();
    check("fl_src0", 64'(bus.mem_source), 64'd0);
    check("fl_read", 64'(bus.mem_read), 64'd1);
    bus.delete_tagged = 1'b1;
    step();
    check("fl_read_drop", 64'(bus.mem_read), 64'd0);
    check("fl_no_ready", 64'(bus.ch_ready), 64'd0);
    bus.ch_req    = 2'b11;
    bus.mem_ready = 1'b1;
    step();
    check("fl_grant1", 64'(bus.mem_source), 64'd1);
    check("fl_addr1", 64'(bus.mem_address), 64'h300);
    check("fl_no_ready2", 64'(bus.ch_ready), 64'd0);
    bus.mem_ready     = 1'b0;
    bus.delete_tagged = 1'b0;
    bus.ch_req        = 2'b10;
    step();
    check("fl_still_wait", 64'(bus.mem_read), 64'd1);
    check("fl_no_ready3", 64'(bus.ch_ready), 64'd0);
    bus.mem_rdata = 32'h12345678;
    bus.mem_ready = 1'b1;
    step();
    check("fl_ready1", 64'(bus.ch_ready), 64'b10);
    check("fl_rdata", 64'(bus.ch_rdata), 64'h12345678);
    bus.ch_req    = 2'b00;
    bus.mem_ready = 1'b0;
    step();

    // Reset in the middle of a wait clears outputs at once.
    set_ch(1, 1'b0, 32'h200, 32'h0, 4'h0);
    bus.ch_req = 2'b10;
    step();
    check("mr_read", 64'(bus.mem_read), 64'd1);
    check("mr_src", 64'(bus.mem_source), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_read0", 64'(bus.mem_read), 64'd0);
    check("mr_addr0", 64'(bus.mem_address), 64'd0);
    check("mr_src0", 64'(bus.mem_source), 64'd0);
    check("mr_rdata0", 64'(bus.ch_rdata), 64'd0);
    check("mr_ready0", 64'(bus.ch_ready), 64'd0);
    bus.ch_req    = 2'b00;
    bus.mem_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("mr_idle_ready", 64'(bus.ch_ready), 64'd0);
    check("mr_idle_read", 64'(bus.mem_read), 64'd0);
    step();
    check("mr_idle_ready2", 64'(bus.ch_ready), 64'd0);
    bus.mem_ready = 1'b0;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    // No memory answer: timeout completion in the 6th cycle after the command.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_ch(0, 1'b0, 32'h100, 32'h0, 4'h0);
    bus.ch_req = 2'b01;
    step();
    check("to_read", 64'(bus.mem_read), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("to_wait", 64'(bus.ch_ready), 64'd0);
    end
    step();
    check("to_ready", 64'(bus.ch_ready), 64'b01);
    check("to_error", 64'(bus.ch_error), 64'd1);
    check("to_rdata", 64'(bus.ch_rdata), 64'd0);
    bus.ch_req = 2'b00;
    step();
    check("to_error_clr", 64'(bus.ch_error), 64'd0);
`else
    check("no_tmo_error", 64'(bus.ch_error), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
